// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
//   Shared types and constants for the boot-time instruction-memory loader.
//   - loader_state_t : frame parser states
//   - DEFAULT_SYNC_BYTE : default frame start marker
//   - max_words()    : largest image (in words) that fits the byte-wide imem
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        SYNC,
        LEN,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Memory depth in bytes divided by bytes per instruction word.
    function automatic int max_words(input int addr_w, input int data_w);
        return (1 << addr_w) / (data_w / 8);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Parses a framed program image from a byte stream and writes it, one byte
//   per cycle, into the byte-wide instruction memory. The core is held in
//   reset until a complete image with a matching checksum is resident.
//
//   Frame: SYNC_BYTE, N (word count), N*BPW payload bytes (big-endian words,
//   first byte at the lowest address), 8-bit sum of the payload bytes.
//
// Ports
//   clk        : clock
//   rst_n      : synchronous active-low reset
//   in_valid   : byte-stream valid
//   in_data    : byte-stream data
//   in_ready   : loader accepts a byte (transfer on in_valid && in_ready)
//   mem_we     : imem byte write enable (one-cycle pulse per payload byte)
//   mem_addr   : imem byte address
//   mem_wdata  : imem byte data
//   cpu_rst_n  : processor reset, low holds the core
//   load_done  : a valid image is resident
//   load_err   : the last frame was rejected
//   load_words : word count of the last successful image
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_BUS_WIDTH = 5,
    parameter int         DATA_BUS_WIDTH = 32,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      mem_we,
    output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
    output logic [7:0]                mem_wdata,
    output logic                      cpu_rst_n,
    output logic                      load_done,
    output logic                      load_err,
    output logic [7:0]                load_words
);

    localparam int BPW       = DATA_BUS_WIDTH / 8;
    localparam int MAX_WORDS = max_words(ADDR_BUS_WIDTH, DATA_BUS_WIDTH);

    loader_state_t             state;
    logic [7:0]                sum;
    logic [ADDR_BUS_WIDTH-1:0] byte_cnt;
    // Index of the final payload byte; N is bounded in LEN so this never
    // exceeds the memory depth and byte_cnt never has to wrap.
    logic [ADDR_BUS_WIDTH-1:0] last_idx;
    logic [7:0]                n_words;

    logic accept;
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= SYNC;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rst_n  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            load_words <= '0;
            sum        <= '0;
            byte_cnt   <= '0;
            last_idx   <= '0;
            n_words    <= '0;
        end else begin
            in_ready <= 1'b1;
            mem_we   <= 1'b0;

            if (accept) begin
                case (state)
                    // Hunting for a frame start. A sync byte seen while an
                    // image is resident (DONE) or after a reject (ERR) drops
                    // the core back into reset before any overwrite begins.
                    SYNC, DONE, ERR: begin
                        if (in_data == SYNC_BYTE) begin
                            state     <= LEN;
                            cpu_rst_n <= 1'b0;
                            load_done <= 1'b0;
                        end
                    end

                    LEN: begin
                        if (int'(in_data) > MAX_WORDS) begin
                            state     <= ERR;
                            load_err  <= 1'b1;
                            load_done <= 1'b0;
                            cpu_rst_n <= 1'b0;
                        end else begin
                            sum      <= '0;
                            byte_cnt <= '0;
                            n_words  <= in_data;
                            if (in_data == 8'd0) begin
                                state <= CSUM;
                            end else begin
                                state    <= DATA;
                                last_idx <= ADDR_BUS_WIDTH'(int'(in_data) * BPW - 1);
                            end
                        end
                    end

                    // Bytes land at consecutive addresses in arrival order,
                    // which gives big-endian word layout in imem.
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= byte_cnt;
                        mem_wdata <= in_data;
                        sum       <= sum + in_data;
                        load_err  <= 1'b0;
                        if (byte_cnt == last_idx) begin
                            state <= CSUM;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end

                    CSUM: begin
                        if (in_data == sum) begin
                            state      <= DONE;
                            cpu_rst_n  <= 1'b1;
                            load_done  <= 1'b1;
                            load_err   <= 1'b0;
                            load_words <= n_words;
                        end else begin
                            state     <= ERR;
                            load_err  <= 1'b1;
                            load_done <= 1'b0;
                            cpu_rst_n <= 1'b0;
                        end
                    end

                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader (ADDR_BUS_WIDTH=5, DATA_BUS_WIDTH=32).
//   A negedge monitor keeps a copy of every byte written to imem and a count
//   of write pulses; the main sequence compares outputs against hand-computed
//   values.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst_n;
    logic       load_done;
    logic       load_err;
    logic [7:0] load_words;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [7:0] model [0:31];

    imem_loader #(
        .ADDR_BUS_WIDTH(5),
        .DATA_BUS_WIDTH(32),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .load_err  (load_err),
        .load_words(load_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture imem writes away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            model[mem_addr] = mem_wdata;
            we_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Idle for gap cycles, present one byte for one cycle, then return in the
    // cycle after acceptance (registered results are visible).
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
    endtask

    // Payload byte: write pulse must appear exactly one cycle after acceptance.
    task automatic send_data(input logic [7:0] b, input int addr, input int gap);
        send(b, gap);
        chk("mem_we",    32'(mem_we),    32'd1);
        chk("mem_addr",  32'(mem_addr),  32'(addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(b));
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // ---- reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst in_ready",   32'(in_ready),   32'd0);
        chk("rst mem_we",     32'(mem_we),     32'd0);
        chk("rst mem_addr",   32'(mem_addr),   32'd0);
        chk("rst mem_wdata",  32'(mem_wdata),  32'd0);
        chk("rst cpu_rst_n",  32'(cpu_rst_n),  32'd0);
        chk("rst load_done",  32'(load_done),  32'd0);
        chk("rst load_err",   32'(load_err),   32'd0);
        chk("rst load_words", 32'(load_words), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("ready after rst", 32'(in_ready), 32'd1);

        // ---- nominal load with gaps: sum FF+C4+A3+03 = 0x269 -> 0x69
        send(8'hA5, 1);
        send(8'h01, 2);
        send_data(8'hFF, 0, 0);
        send_data(8'hC4, 1, 3);
        send_data(8'hA3, 2, 1);
        send_data(8'h03, 3, 2);
        chk("nom cpu held", 32'(cpu_rst_n), 32'd0);
        send(8'h69, 1);
        chk("nom cpu_rst_n",  32'(cpu_rst_n),  32'd1);
        chk("nom load_done",  32'(load_done),  32'd1);
        chk("nom load_err",   32'(load_err),   32'd0);
        chk("nom load_words", 32'(load_words), 32'd1);
        chk("nom we_cnt",     32'(we_cnt),     32'd4);
        chk("nom img0", 32'(model[0]), 32'hFF);
        chk("nom img3", 32'(model[3]), 32'h03);

        // ---- bad checksum, entered from DONE
        send(8'hA5, 0);
        chk("redo cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("redo load_done", 32'(load_done), 32'd0);
        send(8'h01, 0);
        send_data(8'hFF, 0, 0);
        send_data(8'hC4, 1, 0);
        send_data(8'hA3, 2, 0);
        send_data(8'h03, 3, 0);
        send(8'h6A, 0);
        chk("bad load_err",  32'(load_err),  32'd1);
        chk("bad load_done", 32'(load_done), 32'd0);
        chk("bad cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("bad we_cnt",    32'(we_cnt),    32'd8);

        // ---- recovery: 11+22+33+44 = 0xAA
        send(8'hA5, 0);
        send(8'h01, 0);
        chk("rec err held", 32'(load_err), 32'd1);
        send_data(8'h11, 0, 0);
        chk("rec err clr", 32'(load_err), 32'd0);
        send_data(8'h22, 1, 0);
        send_data(8'h33, 2, 1);
        send_data(8'h44, 3, 0);
        send(8'hAA, 0);
        chk("rec load_done", 32'(load_done), 32'd1);
        chk("rec cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        chk("rec img0", 32'(model[0]), 32'h11);
        chk("rec img3", 32'(model[3]), 32'h44);

        // ---- oversize length (9 > 8 words)
        base = we_cnt;
        send(8'hA5, 0);
        send(8'h09, 0);
        chk("ovr load_err",  32'(load_err),  32'd1);
        chk("ovr load_done", 32'(load_done), 32'd0);
        chk("ovr cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        send(8'h00, 0);
        chk("ovr dropped err", 32'(load_err), 32'd1);

        // ---- zero length
        send(8'hA5, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        chk("zero load_done",  32'(load_done),  32'd1);
        chk("zero load_err",   32'(load_err),   32'd0);
        chk("zero load_words", 32'(load_words), 32'd0);
        chk("zero no writes",  32'(we_cnt),     32'(base));

        // ---- sync hunting from DONE
        send(8'h12, 0);
        send(8'h34, 0);
        chk("hunt done held", 32'(load_done), 32'd1);
        send(8'hA5, 0);
        send(8'h01, 0);
        send_data(8'h00, 0, 0);
        send_data(8'h00, 1, 0);
        send_data(8'h00, 2, 0);
        send_data(8'h13, 3, 0);
        send(8'h13, 0);
        chk("hunt load_done",  32'(load_done),  32'd1);
        chk("hunt load_words", 32'(load_words), 32'd1);
        base = we_cnt;
        send(8'h00, 0);
        chk("hunt trail done", 32'(load_done), 32'd1);
        chk("hunt trail nowr", 32'(we_cnt),    32'(base));
        chk("hunt img3", 32'(model[3]), 32'h13);

        // ---- reset mid-load after two payload bytes
        send(8'hA5, 0);
        send(8'h02, 0);
        send_data(8'hAA, 0, 0);
        send_data(8'hBB, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid in_ready",   32'(in_ready),   32'd0);
        chk("mid mem_we",     32'(mem_we),     32'd0);
        chk("mid cpu_rst_n",  32'(cpu_rst_n),  32'd0);
        chk("mid load_done",  32'(load_done),  32'd0);
        chk("mid load_err",   32'(load_err),   32'd0);
        chk("mid load_words", 32'(load_words), 32'd0);
        rst_n = 1'b1;
        base = we_cnt;
        send(8'hCC, 0);
        send(8'hDD, 0);
        chk("mid no writes", 32'(we_cnt), 32'(base));
        chk("mid kept0", 32'(model[0]), 32'hAA);
        chk("mid kept1", 32'(model[1]), 32'hBB);

        // full reload: 01..08 sums to 0x24
        send(8'hA5, 0);
        send(8'h02, 0);
        for (int k = 0; k < 8; k++) send_data(8'(k + 1), k, k % 2);
        send(8'h24, 0);
        chk("reload done",  32'(load_done),  32'd1);
        chk("reload words", 32'(load_words), 32'd2);
        chk("reload img7",  32'(model[7]),   32'h08);

        // ---- reload from DONE at maximum size: bytes 0..31 sum 496 -> 0xF0
        send(8'hA5, 0);
        chk("max cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        chk("max load_done", 32'(load_done), 32'd0);
        send(8'h08, 0);
        base = we_cnt;
        for (int k = 0; k < 32; k++) send_data(8'(k), k, 0);
        send(8'hF0, 0);
        chk("max load_done",  32'(load_done),  32'd1);
        chk("max cpu_up",     32'(cpu_rst_n),  32'd1);
        chk("max load_words", 32'(load_words), 32'd8);
        chk("max we_cnt",     32'(we_cnt),     32'(base + 32));
        for (int k = 0; k < 32; k++) chk("max img", 32'(model[k]), 32'(k));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
